// File: rtl/drum_hit_scheduler_if.sv
// ============================================================================
// Module      : drum_hit_scheduler_if
// Description : Event handshake bundle between the drum hit scheduler and its
//               consumer (game/scoring FSM).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface drum_hit_scheduler_if;
    logic       evt_valid;
    logic       evt_ready;
    logic [2:0] evt_pad;
    logic [7:0] evt_level;

    modport master (
        output evt_valid,
        output evt_pad,
        output evt_level,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_pad,
        input  evt_level,
        output evt_ready
    );
endinterface

`default_nettype wire

// File: rtl/drum_hit_scheduler.sv
// ============================================================================
// Module      : drum_hit_scheduler
// Description : Edge-detects per-pad hit indicators, applies a retrigger
//               holdoff, round-robin arbitrates pending hits into an event
//               FIFO and presents one {pad, level} event per handshake.
//               Optional macro HIT_VELOCITY_EN stores the captured level.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module drum_hit_scheduler #(
    parameter int NPADS          = 5,
    parameter int HOLDOFF_CYCLES = 2_500_000,
    parameter int FIFO_DEPTH     = 4
) (
    input  wire logic                 CLK,
    input  wire logic                 RST,
    input  wire logic [NPADS-1:0]     hit_in,
    input  wire logic [8*NPADS-1:0]   level_in,
    drum_hit_scheduler_if.master      evt,
    output logic      [NPADS-1:0]     pad_busy,
    output logic                      overflow
);

    localparam int c_HOLD_W = $clog2(HOLDOFF_CYCLES);
    localparam int c_PW     = $clog2(FIFO_DEPTH);
    localparam int c_CW     = c_PW + 1;
`ifdef HIT_VELOCITY_EN
    localparam int c_EW     = 11;
`else
    localparam int c_EW     = 3;
`endif
    localparam logic [c_HOLD_W-1:0] c_HOLD_LOAD = c_HOLD_W'(HOLDOFF_CYCLES - 1);

    logic [NPADS-1:0] r_hit_q;
    logic [NPADS-1:0] w_rise;
    logic [NPADS-1:0] w_accept;
    logic [NPADS-1:0] w_lost;
    logic [NPADS-1:0] w_busy;
    logic [NPADS-1:0] w_pending;
    logic [NPADS-1:0] w_grant_vec;
    logic [2:0]       w_grant_idx;
    logic             w_grant_any;
    logic [2:0]       r_rr_ptr;
    logic             r_overflow;

`ifdef HIT_VELOCITY_EN
    logic [7:0]       w_lvl_cap [NPADS];
    logic [7:0]       w_grant_lvl;
`else
    logic             w_unused_level;
    assign w_unused_level = ^level_in;
`endif

    logic [c_EW-1:0]  r_mem [FIFO_DEPTH];
    logic [c_PW-1:0]  r_wr_ptr;
    logic [c_PW-1:0]  r_rd_ptr;
    logic [c_PW-1:0]  w_rd_next;
    logic [c_CW-1:0]  r_count;
    logic [c_CW-1:0]  w_count_next;
    logic [c_EW-1:0]  w_entry;
    logic [c_EW-1:0]  w_head_next;
    logic [c_EW-1:0]  r_head;
    logic             r_evt_valid;
    logic             w_pop;
    logic             w_push;
    logic             w_push_ok;

    // ------------------------------------------------------------------
    // Per-pad edge detect, holdoff timer and pending flag
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NPADS; i++) begin : g_pad
        logic [c_HOLD_W-1:0] r_hold_cnt;
        logic                r_busy;
        logic                r_pend;

        assign w_rise[i]    = hit_in[i] & ~r_hit_q[i];
        assign w_accept[i]  = w_rise[i] & ~r_busy;
        // A pad being granted this very cycle frees its slot for the new hit.
        assign w_lost[i]    = w_accept[i] & r_pend & ~w_grant_vec[i];
        assign w_busy[i]    = r_busy;
        assign w_pending[i] = r_pend;

        always_ff @(posedge CLK) begin
            if (RST) begin
                r_hold_cnt <= '0;
                r_busy     <= 1'b0;
                r_pend     <= 1'b0;
            end else begin
                if (w_accept[i]) begin
                    r_busy     <= 1'b1;
                    r_hold_cnt <= c_HOLD_LOAD;
                end else if (r_busy) begin
                    if (r_hold_cnt == '0) begin
                        r_busy <= 1'b0;
                    end else begin
                        r_hold_cnt <= r_hold_cnt - 1'b1;
                    end
                end
                if (w_accept[i]) begin
                    r_pend <= 1'b1;
                end else if (w_grant_vec[i]) begin
                    r_pend <= 1'b0;
                end
            end
        end

`ifdef HIT_VELOCITY_EN
        logic [7:0] r_lvl_cap;
        assign w_lvl_cap[i] = r_lvl_cap;

        always_ff @(posedge CLK) begin
            if (RST) begin
                r_lvl_cap <= '0;
            end else if (w_accept[i] && !w_lost[i]) begin
                r_lvl_cap <= level_in[8*i +: 8];
            end
        end
`endif
    end

    // ------------------------------------------------------------------
    // Round-robin arbiter: first pending pad at or above rr_ptr, wrapping
    // ------------------------------------------------------------------
    assign w_pop     = r_evt_valid & evt.evt_ready;
    assign w_push_ok = (r_count < c_CW'(FIFO_DEPTH)) | w_pop;

    always_comb begin : p_arbiter
        int j;
        w_grant_vec = '0;
        w_grant_idx = '0;
        w_grant_any = 1'b0;
`ifdef HIT_VELOCITY_EN
        w_grant_lvl = '0;
`endif
        j = 0;
        for (int k = 0; k < NPADS; k++) begin
            j = int'(r_rr_ptr) + k;
            if (j >= NPADS) begin
                j = j - NPADS;
            end
            if (!w_grant_any && w_pending[j] && w_push_ok) begin
                w_grant_any    = 1'b1;
                w_grant_idx    = 3'(j);
                w_grant_vec[j] = 1'b1;
`ifdef HIT_VELOCITY_EN
                w_grant_lvl    = w_lvl_cap[j];
`endif
            end
        end
    end

    assign w_push = w_grant_any;

`ifdef HIT_VELOCITY_EN
    assign w_entry = {w_grant_idx, w_grant_lvl};
`else
    assign w_entry = w_grant_idx;
`endif

    // ------------------------------------------------------------------
    // Event FIFO with registered head; the head register is loaded with
    // whatever entry will sit at the read pointer after this edge.
    // ------------------------------------------------------------------
    assign w_rd_next    = r_rd_ptr + c_PW'(w_pop);
    assign w_count_next = r_count + c_CW'(w_push) - c_CW'(w_pop);
    assign w_head_next  = (w_push && (r_wr_ptr == w_rd_next)) ? w_entry : r_mem[w_rd_next];

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_hit_q     <= '0;
            r_rr_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_head      <= '0;
            r_evt_valid <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_hit_q     <= hit_in;
            r_count     <= w_count_next;
            r_rd_ptr    <= w_rd_next;
            r_head      <= w_head_next;
            r_evt_valid <= (w_count_next != '0);
            if (|w_lost) begin
                r_overflow <= 1'b1;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_rr_ptr <= (w_grant_idx == 3'(NPADS - 1)) ? 3'd0 : w_grant_idx + 3'd1;
            end
        end
    end

    assign evt.evt_valid = r_evt_valid;
    assign evt.evt_pad   = r_head[c_EW-1 -: 3];
`ifdef HIT_VELOCITY_EN
    assign evt.evt_level = r_head[7:0];
`else
    assign evt.evt_level = 8'd0;
`endif
    assign pad_busy      = w_busy;
    assign overflow      = r_overflow;

endmodule

`default_nettype wire
